// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution slice: branch type codes and
// helpers for the saturating counter reset value and maximum value.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_EQ   = 3'b000,
        BR_NE   = 3'b001,
        BR_LT   = 3'b010,
        BR_LTU  = 3'b011,
        BR_GT   = 3'b100,
        BR_GEU  = 3'b101,
        BR_JUMP = 3'b110,
        BR_NONE = 3'b111
    } br_type_e;

    // Weakly not-taken start point; a 1-bit counter simply starts at 0.
    function automatic int unsigned ctr_reset_val(input int unsigned ctr_bits);
        return (ctr_bits <= 32'd1) ? 32'd0 : ((32'd1 << (ctr_bits - 32'd1)) - 32'd1);
    endfunction

    function automatic int unsigned ctr_max_val(input int unsigned ctr_bits);
        return (32'd1 << ctr_bits) - 32'd1;
    endfunction

    // Only conditional branches train the table; JUMP and NONE leave it alone.
    function automatic logic updates_table(input br_type_e t);
        return (t != BR_JUMP) && (t != BR_NONE);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch lookup, execute request and resolution result signals of the branch
// resolution unit. master = pipeline side, slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    import branch_pkg::*;

    logic [XLEN-1:0] f_pc;
    logic            f_pred_taken;
    logic            ex_valid;
    br_type_e        ex_br_type;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic            ex_pred_taken;
    logic            res_valid;
    logic            res_taken;
    logic            res_mispredict;

    modport master (
        output f_pc, ex_valid, ex_br_type, ex_pc, ex_a, ex_b, ex_pred_taken,
        input  f_pred_taken, res_valid, res_taken, res_mispredict
    );

    modport slave (
        input  f_pc, ex_valid, ex_br_type, ex_pc, ex_a, ex_b, ex_pred_taken,
        output f_pred_taken, res_valid, res_taken, res_mispredict
    );

endinterface

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation on full-width operands.
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  br_type_e        br_type,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            taken
);

    // Select the comparison for the branch type; signed types use bit XLEN-1 as sign.
    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_EQ:   taken = (a == b);
            BR_NE:   taken = (a != b);
            BR_LT:   taken = ($signed(a) < $signed(b));
            BR_LTU:  taken = (a < b);
            BR_GT:   taken = ($signed(a) > $signed(b));
            BR_GEU:  taken = (a >= b);
            BR_JUMP: taken = 1'b1;
            BR_NONE: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage with a direct-mapped table of saturating counters.
// Resolves execute-stage branches into registered taken/mispredict results and
// trains the counter table that fetch reads combinationally.
// Optional feature macro: BRU_PERF_CNT_EN adds branch and mispredict counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CTR_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_unit_if.slave bus
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]          perf_br_cnt,
    output logic [31:0]          perf_mispred_cnt
`endif
);

    localparam int IDX = $clog2(BHT_DEPTH);
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset_val(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctr_max_val(CTR_BITS));

    logic [IDX-1:0] f_idx;
    logic [IDX-1:0] ex_idx;
    logic           ex_taken;
    logic           ex_update;
    logic           res_valid_reg;
    logic           res_taken_reg;
    logic           res_mispredict_reg;
    logic [BHT_DEPTH-1:0][CTR_BITS-1:0] ctr_vec;

    // Upper PC bits alias onto the table by design.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.f_pc, bus.ex_pc};

    assign f_idx     = bus.f_pc[IDX+1:2];
    assign ex_idx    = bus.ex_pc[IDX+1:2];
    assign ex_update = bus.ex_valid && updates_table(bus.ex_br_type);

    branch_compare #(
        .XLEN(XLEN)
    ) u_compare (
        .br_type(bus.ex_br_type),
        .a      (bus.ex_a),
        .b      (bus.ex_b),
        .taken  (ex_taken)
    );

    // One saturating counter per entry; each entry decodes its own write hit.
    for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
        logic [CTR_BITS-1:0] ctr_reg;
        logic [CTR_BITS-1:0] ctr_next;
        logic                hit;

        assign hit = ex_update && (ex_idx == IDX'(gi));

        // Saturating increment on taken, saturating decrement on not taken.
        always_comb begin
            ctr_next = ctr_reg;
            if (hit) begin
                if (ex_taken) begin
                    if (ctr_reg != CTR_MAX) ctr_next = ctr_reg + CTR_BITS'(1);
                end else begin
                    if (ctr_reg != '0) ctr_next = ctr_reg - CTR_BITS'(1);
                end
            end
        end

        // Counter state; reset reinitialises every entry to weakly not-taken.
        always_ff @(posedge clk) begin
            if (rst) ctr_reg <= CTR_RST;
            else     ctr_reg <= ctr_next;
        end

        assign ctr_vec[gi] = ctr_reg;
    end

    // Read sees the pre-update value when lookup and update hit one entry.
    assign bus.f_pred_taken = ctr_vec[f_idx][CTR_BITS-1];

    // Result registers; outputs are forced low for bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_reg      <= 1'b0;
            res_taken_reg      <= 1'b0;
            res_mispredict_reg <= 1'b0;
        end else begin
            res_valid_reg      <= bus.ex_valid;
            res_taken_reg      <= bus.ex_valid && ex_taken;
            res_mispredict_reg <= bus.ex_valid && (ex_taken != bus.ex_pred_taken);
        end
    end

    assign bus.res_valid      = res_valid_reg;
    assign bus.res_taken      = res_taken_reg;
    assign bus.res_mispredict = res_mispredict_reg;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_br_cnt_reg;
    logic [31:0] perf_mispred_cnt_reg;

    // Count each presented result; both counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_cnt_reg      <= '0;
            perf_mispred_cnt_reg <= '0;
        end else if (res_valid_reg) begin
            perf_br_cnt_reg <= perf_br_cnt_reg + 32'd1;
            if (res_mispredict_reg) perf_mispred_cnt_reg <= perf_mispred_cnt_reg + 32'd1;
        end
    end

    assign perf_br_cnt      = perf_br_cnt_reg;
    assign perf_mispred_cnt = perf_mispred_cnt_reg;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus pushes hand-computed
// expected results, a monitor pops and compares whenever res_valid is shown.
module tb_branch_resolve_unit;
    import branch_pkg::*;

    typedef struct {
        logic  taken;
        logic  misp;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(32)) bus();

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mispred_cnt;
`endif

    branch_resolve_unit #(
        .XLEN(32),
        .BHT_DEPTH(64),
        .CTR_BITS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_br_cnt(perf_br_cnt),
        .perf_mispred_cnt(perf_mispred_cnt)
`endif
    );

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic issue(input string name, input br_type_e t, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic pred,
                         input logic exp_taken, input logic exp_misp);
        exp_t e;
        @(negedge clk);
        bus.ex_valid      = 1'b1;
        bus.ex_br_type    = t;
        bus.ex_a          = a;
        bus.ex_b          = b;
        bus.ex_pc         = pc;
        bus.ex_pred_taken = pred;
        e.taken = exp_taken;
        e.misp  = exp_misp;
        e.name  = name;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.ex_valid = 1'b0;
    endtask

    task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
        bus.f_pc = pc;
        #1;
        check1(name, 32'(bus.f_pred_taken), 32'(exp));
    endtask

    // Monitor: compare each presented result against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.res_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_res: res_valid=1 with no outstanding branch");
                end else begin
                    e = sb_q.pop_front();
                    check1({e.name, ".taken"}, 32'(bus.res_taken), 32'(e.taken));
                    check1({e.name, ".misp"}, 32'(bus.res_mispredict), 32'(e.misp));
                end
            end else begin
                total++;
                if (bus.res_taken !== 1'b0 || bus.res_mispredict !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_outputs: taken=%0b misp=%0b expected 0 0",
                             bus.res_taken, bus.res_mispredict);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ex_valid      = 1'b0;
        bus.ex_br_type    = BR_NONE;
        bus.ex_a          = '0;
        bus.ex_b          = '0;
        bus.ex_pc         = '0;
        bus.ex_pred_taken = 1'b0;
        bus.f_pc          = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check1("rst.res_valid", 32'(bus.res_valid), 32'd0);
        check1("rst.res_taken", 32'(bus.res_taken), 32'd0);
        check1("rst.res_misp", 32'(bus.res_mispredict), 32'd0);
        for (int i = 0; i < 64; i++) check_pred($sformatf("rst.pred[%0d]", i), 32'(i * 4), 1'b0);
`ifdef BRU_PERF_CNT_EN
        check1("rst.perf_br", perf_br_cnt, 32'd0);
        check1("rst.perf_misp", perf_mispred_cnt, 32'd0);
`endif

        // Comparator vectors
        issue("blt_neg",    BR_LT,   32'hFFFFFFFF, 32'd1,        32'h8, 1'b0, 1'b1, 1'b1);
        issue("bltu_big",   BR_LTU,  32'hFFFFFFFF, 32'd1,        32'h8, 1'b0, 1'b0, 1'b0);
        issue("bgt_eq",     BR_GT,   32'd5,        32'd5,        32'h8, 1'b1, 1'b0, 1'b1);
        issue("bgeu_eq",    BR_GEU,  32'd5,        32'd5,        32'h8, 1'b0, 1'b1, 1'b1);
        issue("bgt_signed", BR_GT,   32'd1,        32'hFFFFFFFF, 32'h8, 1'b0, 1'b1, 1'b1);
        issue("beq_ne",     BR_EQ,   32'd5,        32'd6,        32'h8, 1'b0, 1'b0, 1'b0);
        issue("bne_ne",     BR_NE,   32'd5,        32'd6,        32'h8, 1'b1, 1'b1, 1'b0);
        issue("blt_min",    BR_LT,   32'h80000000, 32'h7FFFFFFF, 32'h8, 1'b1, 1'b1, 1'b0);
        idle();

        // Saturation at pc 0x40, counter starts at 01
        issue("sat_t1", BR_EQ, 32'd7, 32'd7, 32'h40, 1'b0, 1'b1, 1'b1);
        idle();
        check_pred("sat.pred_after_t1", 32'h40, 1'b1);
        issue("sat_t2", BR_EQ, 32'd7, 32'd7, 32'h40, 1'b1, 1'b1, 1'b0);
        issue("sat_t3", BR_EQ, 32'd7, 32'd7, 32'h40, 1'b1, 1'b1, 1'b0);
        issue("sat_n1", BR_NE, 32'd7, 32'd7, 32'h40, 1'b1, 1'b0, 1'b1);
        idle();
        check_pred("sat.pred_at_2", 32'h40, 1'b1);
        issue("sat_n2", BR_NE, 32'd7, 32'd7, 32'h40, 1'b1, 1'b0, 1'b1);
        idle();
        check_pred("sat.pred_at_1", 32'h40, 1'b0);
        issue("sat_n3", BR_NE, 32'd7, 32'd7, 32'h40, 1'b0, 1'b0, 1'b0);
        issue("sat_n4", BR_NE, 32'd7, 32'd7, 32'h40, 1'b0, 1'b0, 1'b0);
        issue("sat_t4", BR_EQ, 32'd7, 32'd7, 32'h40, 1'b0, 1'b1, 1'b1);
        idle();
        check_pred("sat.pred_from_0", 32'h40, 1'b0);
        issue("sat_t5", BR_EQ, 32'd7, 32'd7, 32'h40, 1'b0, 1'b1, 1'b1);
        idle();
        check_pred("sat.pred_at_2b", 32'h40, 1'b1);

        // Same-cycle lookup and update of index 5
        issue("simul_t", BR_EQ, 32'd3, 32'd3, 32'h14, 1'b0, 1'b1, 1'b1);
        check_pred("simul.old_pred", 32'h14, 1'b0);
        idle();
        check_pred("simul.new_pred", 32'h14, 1'b1);

        // JUMP / NONE mispredicts, table untouched at 0x80
        issue("jump_mp1", BR_JUMP, 32'd0, 32'd0, 32'h80, 1'b0, 1'b1, 1'b1);
        issue("jump_mp2", BR_JUMP, 32'd0, 32'd0, 32'h80, 1'b0, 1'b1, 1'b1);
        idle();
        check_pred("jump.table_unchanged", 32'h80, 1'b0);
        issue("none_mp", BR_NONE, 32'd0, 32'd0, 32'h80, 1'b1, 1'b0, 1'b1);
        idle();
        check_pred("none.table_unchanged", 32'h80, 1'b0);
        idle();

        // Mid-stream reset with a branch in execute (discarded)
        @(negedge clk);
        rst               = 1'b1;
        bus.ex_valid      = 1'b1;
        bus.ex_br_type    = BR_EQ;
        bus.ex_a          = 32'd7;
        bus.ex_b          = 32'd7;
        bus.ex_pc         = 32'h40;
        bus.ex_pred_taken = 1'b0;
        @(negedge clk);
        rst          = 1'b0;
        bus.ex_valid = 1'b0;
        check1("midrst.res_valid", 32'(bus.res_valid), 32'd0);
        check_pred("midrst.pred_40", 32'h40, 1'b0);
        check_pred("midrst.pred_14", 32'h14, 1'b0);
`ifdef BRU_PERF_CNT_EN
        check1("midrst.perf_br", perf_br_cnt, 32'd0);
        check1("midrst.perf_misp", perf_mispred_cnt, 32'd0);
`endif

        // Ten branches, three mispredicts; first one proves counters restarted at 01
        issue("p1_beq",   BR_EQ,   32'd7, 32'd7, 32'h40, 1'b0, 1'b1, 1'b1);
        idle();
        check_pred("midrst.ctr_was_01", 32'h40, 1'b1);
        issue("p2_bltu",  BR_LTU,  32'd1, 32'd2, 32'h8, 1'b1, 1'b1, 1'b0);
        issue("p3_bne",   BR_NE,   32'd3, 32'd3, 32'h8, 1'b0, 1'b0, 1'b0);
        issue("p4_jump",  BR_JUMP, 32'd0, 32'd0, 32'h8, 1'b1, 1'b1, 1'b0);
        issue("p5_none",  BR_NONE, 32'd0, 32'd0, 32'h8, 1'b0, 1'b0, 1'b0);
        issue("p6_bgeu",  BR_GEU,  32'd2, 32'd1, 32'h8, 1'b1, 1'b1, 1'b0);
        issue("p7_blt",   BR_LT,   32'd2, 32'd1, 32'h8, 1'b1, 1'b0, 1'b1);
        issue("p8_bgt",   BR_GT,   32'd2, 32'd1, 32'h8, 1'b1, 1'b1, 1'b0);
        issue("p9_beq",   BR_EQ,   32'd1, 32'd2, 32'h8, 1'b0, 1'b0, 1'b0);
        issue("p10_none", BR_NONE, 32'd0, 32'd0, 32'h8, 1'b1, 1'b0, 1'b1);
        idle();
        idle();
        idle();
`ifdef BRU_PERF_CNT_EN
        check1("perf.br_cnt", perf_br_cnt, 32'd10);
        check1("perf.mispred_cnt", perf_mispred_cnt, 32'd3);
`endif

        check1("sb.outstanding", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution stage with dynamic prediction for the pipelined core. It evaluates branch conditions on XLEN-wide operands in execute and registers the resolved outcome and a mispredict flag for the fetch/flush logic. It also maintains a direct-mapped table of saturating counters that fetch reads each cycle for its taken/not-taken prediction. It replaces the purely combinational comparator.

## Interface
Parameters:
- XLEN, 32, operand and PC width
- BHT_DEPTH, 64, number of counter entries; power of two, ≥2
- CTR_BITS, 2, saturating counter width; ≥1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- f_pc  in  XLEN  fetch PC for lookup
- f_pred_taken  out  1  prediction for f_pc, combinational
- ex_valid  in  1  branch/jump present in execute this cycle
- ex_br_type  in  3  branch type code
- ex_pc  in  XLEN  PC of the execute instruction
- ex_a, ex_b  in  XLEN  comparison operands
- ex_pred_taken  in  1  prediction the instruction was fetched with
- res_valid  out  1  registered resolution strobe
- res_taken  out  1  registered resolved direction
- res_mispredict  out  1  registered; resolved direction ≠ ex_pred_taken

Reset is synchronous, active-high on `rst`; the block uses the single clock `clk`.

## Operation
- Type codes: 000 BEQ, 001 BNE, 010 BLT (signed), 011 BLTU, 100 BGT (signed, strict), 101 BGEU, 110 JUMP (always taken), 111 NONE (never taken).
- Comparisons are on the full XLEN bits. Signed types treat bit XLEN-1 as the sign.
- Index is IDX = log2(BHT_DEPTH) bits taken from pc[IDX+1:2]. Upper PC bits are ignored (aliasing allowed).
- Lookup: f_pred_taken = MSB of counter[f_pc index]. It is a combinational read of the registered array.
- Update happens on the clock edge when ex_valid=1 and ex_br_type ∈ 000–101:
  - Taken: counter +1, saturating at 2^CTR_BITS−1.
  - Not taken: counter −1, saturating at 0.
- JUMP and NONE never modify the table.
- Resolution: res_valid, res_taken and res_mispredict are all registered from the execute cycle. When ex_valid=0, res_valid=0 and the other two outputs are 0.
- res_mispredict applies to all types, including JUMP with ex_pred_taken=0 and NONE with ex_pred_taken=1.

## Timing
- Reset values:
  - res_valid=0, res_taken=0, res_mispredict=0.
  - Every counter = 2^(CTR_BITS−1)−1 (weakly not-taken; 01 for CTR_BITS=2), so f_pred_taken=0.
  - For CTR_BITS=1, every counter resets to 0.
- Latency: result outputs appear one cycle after the ex_valid cycle.
- Table write takes effect at the edge ending the ex_valid cycle.
- Same-cycle lookup and update of one index: f_pred_taken returns the old (pre-update) value. The new value is visible the next cycle.
- Back-to-back updates to one index in consecutive cycles accumulate; there is no lost update.
- rst asserted mid-stream:
  - The next edge clears the outputs and reinitialises all counters.
  - An ex_valid present in that same cycle is discarded.
- No stall input. The upstream pipeline holds ex_valid low to create bubbles.

## Configuration
- `BRU_PERF_CNT_EN` defined adds two output ports, perf_br_cnt[31:0] and perf_mispred_cnt[31:0].
  - perf_br_cnt increments on every res_valid.
  - perf_mispred_cnt increments on every res_valid with res_mispredict.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and registers are absent; the rest of the behaviour is identical.

## Structure
- Shared package `branch_pkg`:
  - br_type_e enum holding the 3-bit codes above.
  - Localparam functions for the counter reset value and the counter max.
- One sub-module, `branch_compare`: combinational (br_type, a, b) → taken, parametrised by XLEN.
- Counter array, update logic and result registers live in branch_resolve_unit.

## Test plan
- Reset → res_* = 0. With CTR_BITS=2, every index reads f_pred_taken=0. perf counters = 0 when enabled.
- Comparisons:
  - BLT a=0xFFFFFFFF, b=1 → res_taken=1.
  - BLTU with the same operands → res_taken=0.
  - BGT a=b=5 → 0.
  - BGEU a=b=5 → 1.
- Saturation, two taken BEQ at pc=0x40: f_pc=0x40 predicts 1 after the first update; counter=3 after the second. Three not-taken BNE at 0x40 then return the prediction to 0; counter=0 after a fourth.
- Simultaneous access: update and lookup of index 5 in the same cycle → old prediction that cycle, new prediction the next cycle.
- Mispredict: JUMP with ex_pred_taken=0 → res_taken=1, res_mispredict=1, table unchanged. NONE with ex_pred_taken=1 → res_mispredict=1.
- Mid-stream reset: rst asserted together with ex_valid → res_valid=0 next cycle and counters return to 01. With BRU_PERF_CNT_EN, 10 branches including 3 mispredicts → perf_br_cnt=10, perf_mispred_cnt=3.
